// File: rtl/cmult_arbiter.sv
// cmult_arbiter: round-robin arbiter/sequencer sharing one complex multiplier
// between NREQ requesters (one operation in flight at a time).
// Optional feature: define CMULT_ARB_TIMEOUT_EN to build the WAIT timeout
// (TIMEOUT cycles, responds with resp_res=0 and resp_err=1).
module cmult_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_x,
    input  logic [8*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     resp_valid,
    output logic [15:0]         resp_res,
    output logic                resp_err,
    output logic                busy,
    output logic [7:0]          mul_x,
    output logic [7:0]          mul_y,
    output logic                mul_start,
    input  logic [15:0]         mul_res,
    input  logic                mul_ready
);

    localparam int unsigned GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   gnt;
    logic            rdy_q;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            pick_vld;
    logic [7:0]      sel_x;
    logic [7:0]      sel_y;
    logic [GW-1:0]   ptr_next;
    logic            done_c;

`ifdef CMULT_ARB_TIMEOUT_EN
    logic [7:0]      tmo_cnt;
`endif

    // Round-robin pick: first pending requester at or after rr_ptr, plus its operands
    always_comb begin
        pick     = '0;
        cand     = '0;
        pick_vld = 1'b0;
        sel_x    = '0;
        sel_y    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr) + k) % int'(NREQ));
            if (req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick == GW'(i)) begin
                sel_x = req_x[8*i +: 8];
                sel_y = req_y[8*i +: 8];
            end
        end
    end

    // Pointer advance and completion detect; the start cycle is excluded so a
    // ready level left high by the previous operation is never taken as done
    always_comb begin
        ptr_next = (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
        done_c   = mul_ready && !rdy_q && !mul_start;
    end

    // Sequencer: IDLE -> ISSUE -> WAIT -> DONE with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            rdy_q      <= 1'b0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_res   <= '0;
            busy       <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_start  <= 1'b0;
`ifdef CMULT_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            mul_start  <= 1'b0;
            rdy_q      <= mul_ready;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        req_ready <= NREQ'(1) << pick;
                        gnt       <= pick;
                        mul_x     <= sel_x;
                        mul_y     <= sel_y;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b1;
                    rdy_q     <= 1'b0;
`ifdef CMULT_ARB_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                    state     <= WAIT;
                end
                WAIT: begin
                    if (done_c) begin
                        resp_res   <= mul_res;
                        resp_valid <= NREQ'(1) << gnt;
`ifdef CMULT_ARB_TIMEOUT_EN
                        resp_err   <= 1'b0;
`endif
                        state      <= DONE;
                    end
`ifdef CMULT_ARB_TIMEOUT_EN
                    else if (tmo_cnt == 8'(TIMEOUT)) begin
                        resp_res   <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= NREQ'(1) << gnt;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    rr_ptr <= ptr_next;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CMULT_ARB_TIMEOUT_EN
    // No timeout built: the flag is constant low for any legal TIMEOUT
    assign resp_err = (TIMEOUT > 255);
`endif

endmodule

// File: tb/tb_cmult_arbiter.sv
// Self-checking bench for cmult_arbiter: transaction-level reference model
// compared every cycle, plus literal expectations for grant order and results.
module tb_cmult_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_x;
    logic [8*NREQ-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [15:0]       resp_res;
    logic              resp_err;
    logic              busy;
    logic [7:0]        mul_x;
    logic [7:0]        mul_y;
    logic              mul_start;
    logic [15:0]       mul_res;
    logic              mul_ready;

    int tests = 0;
    int errs  = 0;

    cmult_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_res(resp_res), .resp_err(resp_err), .busy(busy),
        .mul_x(mul_x), .mul_y(mul_y), .mul_start(mul_start),
        .mul_res(mul_res), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    // Complex product of signed 4-bit parts, each result part kept to 8 bits
    function automatic logic [15:0] cmul(input logic [7:0] x, input logic [7:0] y);
        int xr, xi, yr, yi, re, im;
        xr = int'($signed(x[7:4]));
        xi = int'($signed(x[3:0]));
        yr = int'($signed(y[7:4]));
        yi = int'($signed(y[3:0]));
        re = xr * yr - xi * yi;
        im = xr * yi + xi * yr;
        return {8'(re), 8'(im)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Multiplier model: ready drops on start, rises lat cycles after start is seen
    int   lat   = 3;
    logic stall = 1'b0;
    int   mcnt  = 0;
    logic mrdy  = 1'b0;
    logic [15:0] mres = '0;
    assign mul_ready = mrdy;
    assign mul_res   = mres;

    always @(posedge clk) begin
        if (stall) begin
            mrdy <= 1'b0;
            mcnt <= 0;
        end else if (mul_start) begin
            mres <= cmul(mul_x, mul_y);
            mrdy <= (lat == 1);
            mcnt <= lat - 1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mrdy <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (describes the current cycle's expected outputs)
    logic              e_ok = 1'b0;
    logic [NREQ-1:0]   e_rr, e_rv;
    logic              e_st, e_busy, e_err;
    logic [7:0]        e_mx, e_my;
    logic [15:0]       e_res;
    int                m_ptr = 0, m_g = 0, m_age = 0;
    logic              m_act = 1'b0, m_done = 1'b0, m_prev = 1'b0;

    // Observed events
    int   glog[$];
    int   acc_cyc = 0, st_cyc = 0, resp_cyc = 0, resp_total = 0;
    logic last_err = 1'b0;

    // Compare DUT against model, log events, then advance model to next cycle
    always @(negedge clk) begin
        int g;
        logic fin, tmo;
        if (e_ok) begin
            chk("req_ready",  32'(req_ready),  32'(e_rr));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("mul_start",  32'(mul_start),  32'(e_st));
            chk("mul_x",      32'(mul_x),      32'(e_mx));
            chk("mul_y",      32'(mul_y),      32'(e_my));
            chk("resp_res",   32'(resp_res),   32'(e_res));
            if (e_rv != '0) chk("resp_err", 32'(resp_err), 32'(e_err));
        end
        if (req_ready != '0) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
            acc_cyc = cyc;
        end
        if (mul_start) st_cyc = cyc;
        if (resp_valid != '0) begin
            resp_cyc   = cyc;
            last_err   = resp_err;
            resp_total = resp_total + 1;
        end

        e_ok = 1'b1;
        if (!rst) begin
            e_rr = '0; e_rv = '0; e_st = 1'b0; e_busy = 1'b0; e_err = 1'b0;
            e_mx = '0; e_my = '0; e_res = '0;
            m_act = 1'b0; m_done = 1'b0; m_ptr = 0;
        end else begin
            e_rr = '0; e_rv = '0; e_st = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
                e_busy = 1'b0;
                m_ptr  = (m_g + 1) % NREQ;
            end else if (!m_act) begin
                g = -1;
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                if (g >= 0) begin
                    e_rr   = NREQ'(1) << g;
                    e_busy = 1'b1;
                    e_mx   = req_x[8*g +: 8];
                    e_my   = req_y[8*g +: 8];
                    m_act  = 1'b1;
                    m_age  = 0;
                    m_g    = g;
                end
            end else begin
                fin = 1'b0;
                tmo = 1'b0;
                if (m_age == 0) e_st = 1'b1;
                else if (m_age >= 2 && mul_ready && !m_prev) fin = 1'b1;
`ifdef CMULT_ARB_TIMEOUT_EN
                else if (m_age == TMO + 1) begin
                    fin = 1'b1;
                    tmo = 1'b1;
                end
`endif
                if (fin) begin
                    e_rv   = NREQ'(1) << m_g;
                    e_res  = tmo ? 16'h0000 : cmul(e_mx, e_my);
                    e_err  = tmo;
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_age = m_age + 1;
                end
            end
        end
        m_prev = mul_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
    endtask

    // Raise requests, drop each on its accept pulse, wait for nresp responses
    task automatic run_reqs(input logic [NREQ-1:0] mask, input int nresp);
        int got = 0;
        int n   = 0;
        req_valid = mask;
        while (got < nresp && n < 200) begin
            tick();
            req_valid = req_valid & ~req_ready;
            if (resp_valid != '0) got++;
            n++;
        end
        chk("resp_count", 32'(got), 32'(nresp));
        tick();
    endtask

    task automatic wait_accept();
        int n = 0;
        while (req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("accept_seen", 32'(req_ready != '0), 32'd1);
        req_valid = req_valid & ~req_ready;
    endtask

    task automatic chk_grant(input int idx, input int exp);
        if (idx < glog.size()) chk($sformatf("grant[%0d]", idx), 32'(glog[idx]), 32'(exp));
        else chk($sformatf("grant_missing[%0d]", idx), 32'(glog.size()), 32'(idx + 1));
    endtask

    initial begin
        int base;
        rst = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
        repeat (2) tick();
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_req_ready", 32'(req_ready),  32'd0);
        chk("rst_resp",      32'(resp_valid), 32'd0);
        chk("rst_res",       32'(resp_res),   32'd0);
        chk("rst_mul_x",     32'(mul_x),      32'd0);
        chk("rst_start",     32'(mul_start),  32'd0);
        rst = 1'b1;
        tick();

        // Single request, 3-cycle multiplier: (3+2i)(1+4i) = -5+14i
        set_ops(0, 8'h32, 8'h14);
        run_reqs(4'b0001, 1);
        chk_grant(0, 0);
        chk("res_single",   32'(resp_res),          32'h0000FB0E);
        chk("start_delay",  32'(st_cyc - acc_cyc),   32'd1);
        chk("latency_l3",   32'(resp_cyc - acc_cyc), 32'd5);

        // Reset rr_ptr, then all four twice: order 0,1,2,3 each time
        rst = 1'b0; tick(); rst = 1'b1;
        set_ops(0, 8'h12, 8'h21);
        set_ops(1, 8'h23, 8'hF1);
        set_ops(2, 8'h34, 8'h3E);
        set_ops(3, 8'h45, 8'h7F);
        run_reqs(4'b1111, 4);
        for (int i = 0; i < 4; i++) chk_grant(1 + i, i);
        run_reqs(4'b1111, 4);
        for (int i = 0; i < 4; i++) chk_grant(5 + i, i);

        // Move rr_ptr to 3, then 2 and 3 together: 3 first, then 2
        run_reqs(4'b0100, 1);
        chk_grant(9, 2);
        run_reqs(4'b1100, 2);
        chk_grant(10, 3);
        chk_grant(11, 2);

        // Stale ready high from the previous op; (7+7i)^2 = 0+98i
        lat = 2;
        set_ops(1, 8'h77, 8'h77);
        run_reqs(4'b0010, 1);
        chk_grant(12, 1);
        chk("res_stale",    32'(resp_res),          32'h00000062);
        chk("latency_l2",   32'(resp_cyc - acc_cyc), 32'd4);

        // Requester 1 raises then drops while requester 0 is served
        lat  = 3;
        base = resp_total;
        req_valid = 4'b0001;
        wait_accept();
        tick();
        req_valid[1] = 1'b1;
        tick(); tick();
        req_valid[1] = 1'b0;
        repeat (12) tick();
        chk_grant(13, 0);
        chk("drop_grants",  32'(glog.size()),       32'd14);
        chk("drop_resps",   32'(resp_total - base), 32'd1);

        // Reset while in WAIT: no response, pending requester re-granted from 0
        stall = 1'b1;
        base  = resp_total;
        req_valid = 4'b0101;
        wait_accept();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("wrst_busy",    32'(busy),       32'd0);
        chk("wrst_resp",    32'(resp_valid), 32'd0);
        chk("wrst_none",    32'(resp_total - base), 32'd0);
        rst   = 1'b1;
        stall = 1'b0;
        run_reqs(4'b0101, 2);
        chk_grant(14, 2);
        chk_grant(15, 0);
        chk_grant(16, 2);

        // Multiplier never completes
        stall = 1'b1;
`ifdef CMULT_ARB_TIMEOUT_EN
        run_reqs(4'b1000, 1);
        chk_grant(17, 3);
        chk("tmo_latency",  32'(resp_cyc - acc_cyc), 32'd12);
        chk("tmo_err",      32'(last_err),          32'd1);
        chk("tmo_res",      32'(resp_res),          32'd0);
`else
        base = resp_total;
        req_valid = 4'b1000;
        wait_accept();
        repeat (40) tick();
        chk_grant(17, 3);
        chk("hang_busy",    32'(busy),              32'd1);
        chk("hang_no_resp", 32'(resp_total - base), 32'd0);
        rst = 1'b0; tick(); rst = 1'b1;
`endif
        stall = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmult_arbiter.md
# cmult_arbiter

Round-robin arbiter and sequencer that shares one complex-multiplier instance (4-bit real/imag operands, 8-bit signed real/imag result, start/ready handshake) between NREQ requesters. It accepts one request at a time, drives the multiplier's operand and start inputs, and detects completion on the multiplier's ready output. It then returns the 16-bit result to the granted requester with a one-cycle response strobe. It sits between the requesting datapath blocks and the multiplier.

## Interface
- NREQ, 4: number of requesters; 2..8.
- TIMEOUT, 63: cycles WAIT tolerates without completion (used only with CMULT_ARB_TIMEOUT_EN); 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low (rst==0 at a clk edge resets).
- req_valid  in  NREQ  request pending, one bit per requester; held until req_ready.
- req_x  in  8*NREQ  per requester {Xreal[3:0], Ximag[3:0]}; slice i = bits [8i+7:8i].
- req_y  in  8*NREQ  per requester {Yreal[3:0], Yimag[3:0]}, same slicing.
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- resp_valid  out  NREQ  one-hot, one-cycle result strobe to the granted requester.
- resp_res  out  16  {resReal[7:0], resImag[7:0]}, valid while resp_valid is nonzero.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- busy  out  1  high in every state except IDLE.
- mul_x  out  8  operand X to the multiplier.
- mul_y  out  8  operand Y to the multiplier.
- mul_start  out  1  multiplier start.
- mul_res  in  16  multiplier result.
- mul_ready  in  1  multiplier ready (level; completion = its rising edge).

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, when any req_valid is set:
  - Grant g = first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Pulse req_ready[g].
  - Latch req_x/req_y slice g into mul_x/mul_y and latch g.
  - Go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - rdy_q is mul_ready registered each cycle; it is cleared in ISSUE.
  - Completion is mul_ready==1 && rdy_q==0.
  - On completion: capture mul_res into resp_res, clear resp_err, go to DONE.
  - A ready level left high from an earlier operation is not accepted as completion.
- DONE:
  - resp_valid[g]=1 for one cycle.
  - rr_ptr <= (g+1) mod NREQ.
  - Go to IDLE.
- mul_x/mul_y stay stable from ISSUE through DONE. They hold their last value in IDLE.
- resp_res is passed through unmodified; the block does no arithmetic. It holds until the next capture.
- Requests that arrive while busy wait. Their req_valid must stay high; the block never drops a request.
- Simultaneous requests are resolved only by rr_ptr, so no requester is granted twice while another is pending.
- A requester dropping req_valid before req_ready is legal; it is simply not granted.

## Timing
- Reset values: state IDLE, rr_ptr 0, rdy_q 0, req_ready 0, resp_valid 0, resp_res 0, resp_err 0, busy 0, mul_x 0, mul_y 0, mul_start 0.
- Accept at cycle t (req_ready) -> mul_start at t+1 -> earliest completion edge at t+2 -> resp_valid at t+3.
- Latency = 3 + multiplier cycles beyond the first.
- Back-to-back: the next accept is possible at the cycle after DONE. Throughput is at most one operation per 4 cycles.
- Reset mid-operation: the FSM returns to IDLE and all outputs clear on the next edge. No response is issued, and the in-flight requester must re-request.

## Configuration
- CMULT_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without completion: go to DONE with resp_res=0 and resp_err=1, and rr_ptr advances normally.
- Undefined: no counter is built, WAIT waits indefinitely, and resp_err is tied 0.

## Test plan
- Reset with rst=0 for 2 cycles -> all outputs 0 and busy=0. Then single request, req 0, X=(3+2i), Y=(1+4i) -> req_ready=0001, mul_start one cycle later. With a 3-cycle multiplier model -> resp_valid=0001 with resp_res={-5, 14}.
- All four req_valid high, each requester with distinct operands -> grants in order 0,1,2,3. Re-raise all four -> order 0,1,2,3 again. Raise 2 and 3 with rr_ptr=3 -> 3 then 2.
- Multiplier model holds ready high from the previous op -> WAIT ignores the stale level and completes only on the new rising edge. X=(7+7i), Y=(7+7i) -> res={0, 98}, observed as the 8-bit value.
- Reset (rst=0) asserted in WAIT -> next cycle state IDLE, busy=0, no resp_valid. A pending requester is re-granted from rr_ptr=0.
- CMULT_ARB_TIMEOUT_EN with TIMEOUT=10 and mul_ready stuck low -> resp_valid exactly 12 cycles after req_ready with resp_err=1 and resp_res=0. Without the macro -> busy stays high and no response.
- Requester 1 drops req_valid while requester 0 is busy -> requester 1 is never granted and receives no response.
